// File: rtl/time_display_scan.sv
// time_display_scan: 4-digit multiplexed 7-segment hh:mm display
// with per-frame snapshot, sequential BCD conversion and field blink.
module time_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic       blink_h,
  input  logic       blink_m,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

  localparam logic [3:0] DASH = 4'hf;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig;
  logic          tick;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          first_q;
  logic          snap;

  logic          cap_en;
  logic          shift_en;
  logic          load_en;

  logic [2:0]    iter_q;
  logic [5:0]    h_bin;
  logic [5:0]    m_bin;
  logic [7:0]    h_bcd;
  logic [7:0]    m_bcd;
  logic [7:0]    h_adj;
  logic [7:0]    m_adj;
  logic          h_bad;
  logic          m_bad;

  logic [3:0]    digit_q [4];
  logic [3:0]    cur;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;

  function automatic logic [7:0] adj(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[3:0] > 4'd4) r[3:0] = b[3:0] + 4'd3;
    if (b[7:4] > 4'd4) r[7:4] = b[7:4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign tick = (ref_cnt == REF_MAX);
  assign snap = first_q | (tick & (dig == 2'd3));

  // Digit-slot timer and active digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      dig     <= 2'd0;
    end else if (tick) begin
      ref_cnt <= '0;
      dig     <= dig + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Free-running blink half-period timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Forces a conversion on the first clock out of reset.
  always_ff @(posedge clk) begin
    if (reset) first_q <= 1'b1;
    else       first_q <= 1'b0;
  end

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Conversion FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (snap) state_d = SHIFT;
      SHIFT:   if (iter_q == 3'd5) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion FSM datapath strobes.
  always_comb begin
    cap_en   = (state_q == IDLE) && snap;
    shift_en = (state_q == SHIFT);
    load_en  = (state_q == LOAD);
  end

  assign h_adj = adj(h_bcd);
  assign m_adj = adj(m_bcd);

  // Snapshot capture and double-dabble shift, both fields in parallel.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= 3'd0;
      h_bin  <= '0;
      m_bin  <= '0;
      h_bcd  <= '0;
      m_bcd  <= '0;
      h_bad  <= 1'b0;
      m_bad  <= 1'b0;
    end else if (cap_en) begin
      iter_q <= 3'd0;
      h_bin  <= {1'b0, hours};
      m_bin  <= minutes;
      h_bcd  <= '0;
      m_bcd  <= '0;
      h_bad  <= (hours > 5'd23);
      m_bad  <= (minutes > 6'd59);
    end else if (shift_en) begin
      iter_q <= iter_q + 3'd1;
      h_bcd  <= {h_adj[6:0], h_bin[5]};
      h_bin  <= {h_bin[4:0], 1'b0};
      m_bcd  <= {m_adj[6:0], m_bin[5]};
      m_bin  <= {m_bin[4:0], 1'b0};
    end
  end

  // Displayed digits change only when a conversion completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
    end else if (load_en) begin
      digit_q[0] <= m_bad ? DASH : m_bcd[3:0];
      digit_q[1] <= m_bad ? DASH : m_bcd[7:4];
      digit_q[2] <= h_bad ? DASH : h_bcd[3:0];
      digit_q[3] <= h_bad ? DASH : h_bcd[7:4];
    end
  end

  // Anode select with field blanking and segment lookup.
  always_comb begin
    cur   = digit_q[dig];
    seg_d = enc(cur);
    an_d  = ~(4'b0001 << dig);
    if (blink_phase && blink_m) an_d[1:0] = 2'b11;
    if (blink_phase && blink_h) an_d[3:2] = 2'b11;
  end

  // Registered display drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= (dig != 2'd2);
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: directed table-driven bench for
// time_display_scan with REFRESH_DIV=8, BLINK_DIV=64.
module tb_time_display_scan;

  logic       clk;
  logic       reset;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       blink_h;
  logic       blink_m;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  time_display_scan #(
    .REFRESH_DIV(8),
    .BLINK_DIV(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hours(hours),
    .minutes(minutes),
    .blink_h(blink_h),
    .blink_m(blink_m),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      h;
    logic [5:0]      m;
    logic            bh;
    logic            bm;
    logic [3:0][6:0] s;
  } vec_t;

  localparam int NV = 9;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;

  vec_t       vecs [NV];
  int         total;
  int         bad;
  int         k;
  int         d;
  logic       ph;
  logic [3:0] ea;

  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    step();
    chk("rst_an", int'(an), 4'b1110);
    chk("rst_seg", int'(seg), S0);
    chk("rst_dp", int'(dp), 1);
    reset = 1'b0;
    k = -1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    k       = 0;
    reset   = 1'b1;
    hours   = '0;
    minutes = '0;
    blink_h = 1'b0;
    blink_m = 1'b0;

    vecs[0] = '{5'd0,  6'd0,  1'b0, 1'b0, {S0, S0, S0, S0}};
    vecs[1] = '{5'd23, 6'd59, 1'b0, 1'b0, {S2, S3, S5, S9}};
    vecs[2] = '{5'd12, 6'd34, 1'b0, 1'b1, {S1, S2, S3, S4}};
    vecs[3] = '{5'd24, 6'd60, 1'b0, 1'b0, {SD, SD, SD, SD}};
    vecs[4] = '{5'd9,  6'd7,  1'b1, 1'b0, {S0, S9, S0, S7}};
    vecs[5] = '{5'd23, 6'd60, 1'b0, 1'b0, {S2, S3, SD, SD}};
    vecs[6] = '{5'd31, 6'd63, 1'b1, 1'b1, {SD, SD, SD, SD}};
    vecs[7] = '{5'd20, 6'd48, 1'b1, 1'b1, {S2, S0, S4, S8}};
    vecs[8] = '{5'd16, 6'd56, 1'b0, 1'b0, {S1, S6, S5, S6}};

    for (int v = 0; v < NV; v++) begin
      hours   = vecs[v].h;
      minutes = vecs[v].m;
      blink_h = vecs[v].bh;
      blink_m = vecs[v].bm;
      do_reset();
      for (int i = 0; i < 192; i++) begin
        step();
        d  = (k / 8) % 4;
        ph = ((k / 64) % 2) == 1;
        ea = ~(4'b0001 << d);
        if (ph && vecs[v].bm) ea[1:0] = 2'b11;
        if (ph && vecs[v].bh) ea[3:2] = 2'b11;
        chk("an", int'(an), int'(ea));
        chk("dp", int'(dp), int'(d != 2));
        if (k >= 8) chk("seg", int'(seg), int'(vecs[v].s[d]));
        else        chk("seg_pre", int'(seg), int'(S0));
      end
    end

    // Mid-frame input change waits for the next snapshot.
    blink_h = 1'b0;
    blink_m = 1'b0;
    hours   = 5'd12;
    minutes = 6'd7;
    do_reset();
    while (k < 72) begin
      step();
      if (k == 32) chk("mid_old", int'(seg), int'(S7));
      if (k == 40) minutes = 6'd8;
      if (k == 48) chk("mid_s2", int'(seg), int'(S2));
      if (k == 64) chk("mid_hold", int'(seg), int'(S7));
      if (k == 70) chk("mid_e6", int'(seg), int'(S7));
      if (k == 71) begin
        chk("mid_an", int'(an), 4'b1110);
        chk("mid_new", int'(seg), int'(S8));
      end
    end

    // Reset during SHIFT discards the conversion in flight.
    hours   = 5'd12;
    minutes = 6'd34;
    do_reset();
    while (k < 65) begin
      step();
      if (k == 32) chk("ab_prior", int'(seg), int'(S4));
      if (k == 50) begin
        hours   = 5'd5;
        minutes = 6'd17;
      end
    end
    reset = 1'b1;
    step();
    chk("ab_an", int'(an), 4'b1110);
    chk("ab_seg", int'(seg), int'(S0));
    chk("ab_dp", int'(dp), 1);
    step();
    reset = 1'b0;
    k = -1;
    while (k < 16) begin
      step();
      if (k < 8)       chk("ab_zero", int'(seg), int'(S0));
      else if (k < 16) chk("ab_m10", int'(seg), int'(S1));
      else             chk("ab_h1", int'(seg), int'(S5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
